pic_exec_ctrl: RTL and testbench



---
 rtl/pic_exec_ctrl_pkg.sv | 129 ++++++++++++
 rtl/pic_exec_ctrl_inst_decode.sv | 116 +++++++++++
 rtl/pic_exec_ctrl.sv | 128 ++++++++++++
 tb/tb_pic_exec_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pic_exec_ctrl_pkg.sv
// Shared opcode fields, ALU function codes and control-word types for the PIC16C5x sequencer.
// Latency: none (declarations only); no backpressure.
package pic_exec_ctrl_pkg;

    localparam int INST_WIDTH     = 12;
    localparam int ALU_FUNC_WIDTH = 5;
    localparam int ALU_DATA_WIDTH = 8;
    localparam int PC_WIDTH       = 9;

    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IDLE  = 5'd0;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ADDWF = 5'd1;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SUBWF = 5'd2;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDWF = 5'd3;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORWF = 5'd4;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORWF = 5'd5;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_COMF  = 5'd6;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_DECF  = 5'd7;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_INCF  = 5'd8;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MOVF  = 5'd9;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RRF   = 5'd10;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RLF   = 5'd11;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SWAPF = 5'd12;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BCF   = 5'd13;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BSF   = 5'd14;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDLW = 5'd15;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORLW = 5'd16;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORLW = 5'd17;

    // File-register opcodes live in inst[11:6]
    localparam logic [5:0] OP_SUBWF  = 6'b000010;
    localparam logic [5:0] OP_DECF   = 6'b000011;
    localparam logic [5:0] OP_IORWF  = 6'b000100;
    localparam logic [5:0] OP_ANDWF  = 6'b000101;
    localparam logic [5:0] OP_XORWF  = 6'b000110;
    localparam logic [5:0] OP_ADDWF  = 6'b000111;
    localparam logic [5:0] OP_MOVF   = 6'b001000;
    localparam logic [5:0] OP_COMF   = 6'b001001;
    localparam logic [5:0] OP_INCF   = 6'b001010;
    localparam logic [5:0] OP_DECFSZ = 6'b001011;
    localparam logic [5:0] OP_RRF    = 6'b001100;
    localparam logic [5:0] OP_RLF    = 6'b001101;
    localparam logic [5:0] OP_SWAPF  = 6'b001110;
    localparam logic [5:0] OP_INCFSZ = 6'b001111;

    // Bit, literal and branch opcodes live in inst[11:8]
    localparam logic [3:0] OP_BCF   = 4'b0100;
    localparam logic [3:0] OP_BSF   = 4'b0101;
    localparam logic [3:0] OP_BTFSC = 4'b0110;
    localparam logic [3:0] OP_BTFSS = 4'b0111;
    localparam logic [3:0] OP_RETLW = 4'b1000;
    localparam logic [3:0] OP_CALL  = 4'b1001;
    localparam logic [3:0] OP_GOTO0 = 4'b1010;
    localparam logic [3:0] OP_GOTO1 = 4'b1011;
    localparam logic [3:0] OP_MOVLW = 4'b1100;
    localparam logic [3:0] OP_IORLW = 4'b1101;
    localparam logic [3:0] OP_ANDLW = 4'b1110;
    localparam logic [3:0] OP_XORLW = 4'b1111;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_t;

    typedef struct packed {
        logic [ALU_FUNC_WIDTH-1:0] aluFunc;
        logic                      zeroW;
        logic                      zeroF;
        logic                      wrW;
        logic                      wrF;
        logic                      wrStatus;
        logic                      pcLoad;
        logic                      pcSrcStack;
        logic                      stackPush;
        logic                      stackPop;
        logic                      optionWr;
        logic                      trisWr;
        logic                      sleep;
        logic                      clrwdt;
        logic                      skipZero;
        logic                      skipBitClr;
        logic                      skipBitSet;
        logic [PC_WIDTH-1:0]       pcLoadAddr;
    } ctrl_t;

    typedef struct packed {
        logic wrW;
        logic wrF;
        logic wrStatus;
        logic pcInc;
        logic pcLoad;
        logic pcSrcStack;
        logic stackPush;
        logic stackPop;
        logic optionWr;
        logic trisWr;
        logic sleep;
        logic clrwdt;
    } strobe_t;

    function automatic logic [ALU_FUNC_WIDTH-1:0] fileAluFunc(input logic [5:0] op);
        logic [ALU_FUNC_WIDTH-1:0] f;
        case (op)
            OP_SUBWF:  f = ALU_SUBWF;
            OP_DECF:   f = ALU_DECF;
            OP_IORWF:  f = ALU_IORWF;
            OP_ANDWF:  f = ALU_ANDWF;
            OP_XORWF:  f = ALU_XORWF;
            OP_ADDWF:  f = ALU_ADDWF;
            OP_MOVF:   f = ALU_MOVF;
            OP_COMF:   f = ALU_COMF;
            OP_INCF:   f = ALU_INCF;
            OP_DECFSZ: f = ALU_DECF;
            OP_RRF:    f = ALU_RRF;
            OP_RLF:    f = ALU_RLF;
            OP_SWAPF:  f = ALU_SWAPF;
            OP_INCFSZ: f = ALU_INCF;
            default:   f = ALU_IDLE;
        endcase
        return f;
    endfunction

    // SWAPF and the skip variants leave STATUS untouched
    function automatic logic fileSetsStatus(input logic [5:0] op);
        return !(op == OP_SWAPF || op == OP_DECFSZ || op == OP_INCFSZ);
    endfunction

endpackage

// File: rtl/pic_exec_ctrl_inst_decode.sv
// pic_inst_decode: purely combinational instruction word -> control word.
// Latency: zero cycles; no backpressure.
module pic_inst_decode
    import pic_exec_ctrl_pkg::*;
(
    input  logic [INST_WIDTH-1:0] inst,
    output ctrl_t                 ctrl
);

    logic [5:0] fileOp;
    logic       isFile;

    assign fileOp = inst[11:6];
    // SUBWF..INCFSZ occupy inst[11:6] = 000010..001111
    assign isFile = (inst[11:10] == 2'b00) && (inst[9:7] != 3'b000);

    always_comb begin
        ctrl = '0;
        ctrl.aluFunc = ALU_IDLE;
        if (isFile) begin
            ctrl.aluFunc  = fileAluFunc(fileOp);
            ctrl.wrW      = !inst[5];
            ctrl.wrF      = inst[5];
            ctrl.wrStatus = fileSetsStatus(fileOp);
            ctrl.skipZero = (fileOp == OP_DECFSZ) || (fileOp == OP_INCFSZ);
        end else begin
            case (inst[11:8])
                4'b0000: begin
                    case (inst[6:5])
                        2'b00: begin
                            case (inst[4:0])
                                5'd2:               ctrl.optionWr = 1'b1;
                                5'd3:               ctrl.sleep    = 1'b1;
                                5'd4:               ctrl.clrwdt   = 1'b1;
                                5'd5, 5'd6, 5'd7:   ctrl.trisWr   = 1'b1;
                                default:            ;
                            endcase
                        end
                        2'b01: begin
                            ctrl.aluFunc = ALU_IORWF;
                            ctrl.zeroF   = 1'b1;
                            ctrl.wrF     = 1'b1;
                        end
                        2'b10: begin
                            ctrl.aluFunc  = ALU_ANDWF;
                            ctrl.zeroW    = 1'b1;
                            ctrl.wrW      = 1'b1;
                            ctrl.wrStatus = 1'b1;
                        end
                        default: begin
                            ctrl.aluFunc  = ALU_ANDWF;
                            ctrl.zeroW    = 1'b1;
                            ctrl.wrF      = 1'b1;
                            ctrl.wrStatus = 1'b1;
                        end
                    endcase
                end
                OP_BCF: begin
                    ctrl.aluFunc = ALU_BCF;
                    ctrl.wrF     = 1'b1;
                end
                OP_BSF: begin
                    ctrl.aluFunc = ALU_BSF;
                    ctrl.wrF     = 1'b1;
                end
                OP_BTFSC: begin
                    ctrl.aluFunc    = ALU_MOVF;
                    ctrl.skipBitClr = 1'b1;
                end
                OP_BTFSS: begin
                    ctrl.aluFunc    = ALU_MOVF;
                    ctrl.skipBitSet = 1'b1;
                end
                OP_RETLW: begin
                    ctrl.aluFunc    = ALU_IORLW;
                    ctrl.zeroW      = 1'b1;
                    ctrl.wrW        = 1'b1;
                    ctrl.stackPop   = 1'b1;
                    ctrl.pcLoad     = 1'b1;
                    ctrl.pcSrcStack = 1'b1;
                end
                OP_CALL: begin
                    ctrl.pcLoad     = 1'b1;
                    ctrl.stackPush  = 1'b1;
                    ctrl.pcLoadAddr = {1'b0, inst[7:0]};
                end
                OP_GOTO0, OP_GOTO1: begin
                    ctrl.pcLoad     = 1'b1;
                    ctrl.pcLoadAddr = inst[8:0];
                end
                OP_MOVLW: begin
                    ctrl.aluFunc = ALU_IORLW;
                    ctrl.zeroW   = 1'b1;
                    ctrl.wrW     = 1'b1;
                end
                OP_IORLW: begin
                    ctrl.aluFunc  = ALU_IORLW;
                    ctrl.wrW      = 1'b1;
                    ctrl.wrStatus = 1'b1;
                end
                OP_ANDLW: begin
                    ctrl.aluFunc  = ALU_ANDLW;
                    ctrl.wrW      = 1'b1;
                    ctrl.wrStatus = 1'b1;
                end
                OP_XORLW: begin
                    ctrl.aluFunc  = ALU_XORLW;
                    ctrl.wrW      = 1'b1;
                    ctrl.wrStatus = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pic_exec_ctrl.sv
// PIC16C5x Q1-Q4 sequencer: latches an instruction on Q4->Q1, ALU enable in Q3, write/PC strobes in Q4.
// Latency: instruction sampled at edge N writes during clock N+4; free-running, no backpressure.
module pic_exec_ctrl
    import pic_exec_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INST_WIDTH-1:0]     instIn,
    input  logic [ALU_DATA_WIDTH-1:0] aluResultIn,
    output logic [1:0]                qPhaseOut,
    output logic [ALU_FUNC_WIDTH-1:0] aluFuncOut,
    output logic                      aluEnOut,
    output logic [ALU_DATA_WIDTH-1:0] litOut,
    output logic [2:0]                bitSelOut,
    output logic [4:0]                fAddrOut,
    output logic                      zeroWOut,
    output logic                      zeroFOut,
    output logic                      wrWOut,
    output logic                      wrFOut,
    output logic                      wrStatusOut,
    output logic                      pcIncOut,
    output logic                      pcLoadOut,
    output logic                      pcSrcStackOut,
    output logic [PC_WIDTH-1:0]       pcLoadAddrOut,
    output logic                      stackPushOut,
    output logic                      stackPopOut,
    output logic                      optionWrOut,
    output logic                      trisWrOut,
    output logic                      sleepOut,
    output logic                      clrwdtOut
);

    phase_t                  phase, phaseNext;
    ctrl_t                   ctrl, ctrlNext;
    strobe_t                 strobe, strobeNext;
    logic [7:0]              irLit;
    logic [INST_WIDTH-1:0]   irNext;
    logic                    flush;
    logic                    flushNext;
    logic                    skip;
    logic                    bitVal;
    logic                    aluEn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= Q1;
        else        phase <= phaseNext;
    end

    always_comb begin
        phaseNext = Q1;
        case (phase)
            Q1:      phaseNext = Q2;
            Q2:      phaseNext = Q3;
            Q3:      phaseNext = Q4;
            default: phaseNext = Q1;
        endcase
    end

    // A flushed cycle holds a NOP, so it can never request another skip
    assign bitVal    = aluResultIn[irLit[7:5]];
    assign skip      = !flush && ((ctrl.skipZero   && (aluResultIn == '0)) ||
                                  (ctrl.skipBitClr && !bitVal) ||
                                  (ctrl.skipBitSet && bitVal));
    assign flushNext = skip || ctrl.pcLoad;
    assign irNext    = flushNext ? '0 : instIn;

    pic_inst_decode u_decode (
        .inst (irNext),
        .ctrl (ctrlNext)
    );

    always_comb begin
        strobeNext            = '0;
        strobeNext.wrW        = ctrl.wrW;
        strobeNext.wrF        = ctrl.wrF;
        strobeNext.wrStatus   = ctrl.wrStatus;
        strobeNext.pcInc      = !ctrl.pcLoad;
        strobeNext.pcLoad     = ctrl.pcLoad;
        strobeNext.pcSrcStack = ctrl.pcSrcStack;
        strobeNext.stackPush  = ctrl.stackPush;
        strobeNext.stackPop   = ctrl.stackPop;
        strobeNext.optionWr   = ctrl.optionWr;
        strobeNext.trisWr     = ctrl.trisWr;
        strobeNext.sleep      = ctrl.sleep;
        strobeNext.clrwdt     = ctrl.clrwdt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irLit  <= '0;
            ctrl   <= '0;
            flush  <= 1'b0;
            aluEn  <= 1'b0;
            strobe <= '0;
        end else begin
            if (phase == Q4) begin
                irLit <= irNext[7:0];
                ctrl  <= ctrlNext;
                flush <= flushNext;
            end
            aluEn  <= (phase == Q2);
            strobe <= (phase == Q3) ? strobeNext : '0;
        end
    end

    assign qPhaseOut     = phase;
    assign aluFuncOut    = ctrl.aluFunc;
    assign aluEnOut      = aluEn;
    assign litOut        = irLit;
    assign bitSelOut     = irLit[7:5];
    assign fAddrOut      = irLit[4:0];
    assign zeroWOut      = ctrl.zeroW;
    assign zeroFOut      = ctrl.zeroF;
    assign pcLoadAddrOut = ctrl.pcLoadAddr;
    assign wrWOut        = strobe.wrW;
    assign wrFOut        = strobe.wrF;
    assign wrStatusOut   = strobe.wrStatus;
    assign pcIncOut      = strobe.pcInc;
    assign pcLoadOut     = strobe.pcLoad;
    assign pcSrcStackOut = strobe.pcSrcStack;
    assign stackPushOut  = strobe.stackPush;
    assign stackPopOut   = strobe.stackPop;
    assign optionWrOut   = strobe.optionWr;
    assign trisWrOut     = strobe.trisWr;
    assign sleepOut      = strobe.sleep;
    assign clrwdtOut     = strobe.clrwdt;

endmodule

// File: tb/tb_pic_exec_ctrl.sv
// Directed bench for pic_exec_ctrl: hand-computed decode, strobe, skip/flush and reset expectations.
module tb_pic_exec_ctrl;
    import pic_exec_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [11:0] instIn;
    logic [7:0]  aluResultIn;
    logic [1:0]  qPhaseOut;
    logic [4:0]  aluFuncOut;
    logic        aluEnOut;
    logic [7:0]  litOut;
    logic [2:0]  bitSelOut;
    logic [4:0]  fAddrOut;
    logic        zeroWOut, zeroFOut;
    logic        wrWOut, wrFOut, wrStatusOut;
    logic        pcIncOut, pcLoadOut, pcSrcStackOut;
    logic [8:0]  pcLoadAddrOut;
    logic        stackPushOut, stackPopOut;
    logic        optionWrOut, trisWrOut, sleepOut, clrwdtOut;

    logic [11:0] stb;
    assign stb = {wrWOut, wrFOut, wrStatusOut, pcIncOut, pcLoadOut, pcSrcStackOut,
                  stackPushOut, stackPopOut, optionWrOut, trisWrOut, sleepOut, clrwdtOut};

    localparam logic [11:0] S_WRW  = 12'h800;
    localparam logic [11:0] S_WRF  = 12'h400;
    localparam logic [11:0] S_WRS  = 12'h200;
    localparam logic [11:0] S_PCI  = 12'h100;
    localparam logic [11:0] S_PCL  = 12'h080;
    localparam logic [11:0] S_PCS  = 12'h040;
    localparam logic [11:0] S_PUSH = 12'h020;
    localparam logic [11:0] S_POP  = 12'h010;
    localparam logic [11:0] S_OPT  = 12'h008;
    localparam logic [11:0] S_TRIS = 12'h004;
    localparam logic [11:0] S_SLP  = 12'h002;
    localparam logic [11:0] S_WDT  = 12'h001;

    pic_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instIn(instIn), .aluResultIn(aluResultIn),
        .qPhaseOut(qPhaseOut), .aluFuncOut(aluFuncOut), .aluEnOut(aluEnOut),
        .litOut(litOut), .bitSelOut(bitSelOut), .fAddrOut(fAddrOut),
        .zeroWOut(zeroWOut), .zeroFOut(zeroFOut),
        .wrWOut(wrWOut), .wrFOut(wrFOut), .wrStatusOut(wrStatusOut),
        .pcIncOut(pcIncOut), .pcLoadOut(pcLoadOut), .pcSrcStackOut(pcSrcStackOut),
        .pcLoadAddrOut(pcLoadAddrOut), .stackPushOut(stackPushOut), .stackPopOut(stackPopOut),
        .optionWrOut(optionWrOut), .trisWrOut(trisWrOut), .sleepOut(sleepOut), .clrwdtOut(clrwdtOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to a Q4 sample point, bounded in case the phase counter is stuck
    task automatic toQ4(input string tag);
        int n;
        n = 0;
        while (qPhaseOut !== 2'd3 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".sync"}, 32'(qPhaseOut), 32'd3);
    endtask

    // Entered at a Q4 sample point; returns at the Q4 sample point of the new instruction
    task automatic execCycle(input string tag, input logic [11:0] inst, input logic [7:0] res,
                             input logic [4:0] expFunc, input logic [1:0] expZero,
                             input logic [7:0] expLit, input logic [11:0] expStb);
        instIn = inst;
        @(negedge clk);
        chk({tag, ".q1phase"}, 32'(qPhaseOut), 32'd0);
        chk({tag, ".func"},    32'(aluFuncOut), 32'(expFunc));
        chk({tag, ".zero"},    32'({zeroWOut, zeroFOut}), 32'(expZero));
        chk({tag, ".lit"},     32'(litOut), 32'(expLit));
        chk({tag, ".q1stb"},   32'({aluEnOut, stb}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        aluResultIn = res;
        chk({tag, ".q3stb"},   32'({aluEnOut, stb}), 32'h1000);
        @(negedge clk);
        chk({tag, ".q4phase"}, 32'(qPhaseOut), 32'd3);
        chk({tag, ".q4stb"},   32'({aluEnOut, stb}), 32'({1'b0, expStb}));
    endtask

    typedef struct packed {
        logic [11:0] inst;
        logic [4:0]  func;
        logic [1:0]  zero;
        logic [11:0] stb;
    } vec_t;

    vec_t tbl [14] = '{
        {12'h002, ALU_IDLE,  2'b00, S_OPT  | S_PCI},
        {12'h006, ALU_IDLE,  2'b00, S_TRIS | S_PCI},
        {12'h003, ALU_IDLE,  2'b00, S_SLP  | S_PCI},
        {12'h004, ALU_IDLE,  2'b00, S_WDT  | S_PCI},
        {12'h001, ALU_IDLE,  2'b00, S_PCI},
        {12'h065, ALU_ANDWF, 2'b10, S_WRF | S_WRS | S_PCI},
        {12'h025, ALU_IORWF, 2'b01, S_WRF | S_PCI},
        {12'h040, ALU_ANDWF, 2'b10, S_WRW | S_WRS | S_PCI},
        {12'h3A5, ALU_SWAPF, 2'b00, S_WRF | S_PCI},
        {12'h5A3, ALU_BSF,   2'b00, S_WRF | S_PCI},
        {12'h425, ALU_BCF,   2'b00, S_WRF | S_PCI},
        {12'hF0F, ALU_XORLW, 2'b00, S_WRW | S_WRS | S_PCI},
        {12'h105, ALU_IORWF, 2'b00, S_WRW | S_WRS | S_PCI},
        {12'h0A5, ALU_SUBWF, 2'b00, S_WRF | S_WRS | S_PCI}
    };

    initial begin
        logic [11:0] w;
        rst_n       = 1'b0;
        instIn      = 12'h000;
        aluResultIn = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst.phase", 32'(qPhaseOut), 32'd0);
        chk("rst.func",  32'(aluFuncOut), 32'(ALU_IDLE));
        chk("rst.stb",   32'({aluEnOut, stb}), 32'd0);
        chk("rst.flds",  32'({zeroWOut, zeroFOut, litOut, bitSelOut, fAddrOut}), 32'd0);
        chk("rst.addr",  32'(pcLoadAddrOut), 32'd0);

        rst_n = 1'b1;
        toQ4("boot");
        chk("boot.nopq4", 32'(stb), 32'(S_PCI));

        execCycle("addwf", 12'h1E3, 8'h10, ALU_ADDWF, 2'b00, 8'hE3, S_WRF | S_WRS | S_PCI);
        chk("addwf.faddr", 32'(fAddrOut), 32'd3);

        execCycle("decfsz0", 12'h2C5, 8'h00, ALU_DECF,  2'b00, 8'hC5, S_WRW | S_PCI);
        execCycle("flushA",  12'hC12, 8'h00, ALU_IDLE,  2'b00, 8'h00, S_PCI);
        execCycle("movlw",   12'hC12, 8'h00, ALU_IORLW, 2'b10, 8'h12, S_WRW | S_PCI);

        execCycle("decfsz1", 12'h2C5, 8'h01, ALU_DECF,  2'b00, 8'hC5, S_WRW | S_PCI);
        execCycle("noSkipA", 12'hC12, 8'h00, ALU_IORLW, 2'b10, 8'h12, S_WRW | S_PCI);

        execCycle("btfssNo", 12'h723, 8'h00, ALU_MOVF,  2'b00, 8'h23, S_PCI);
        chk("btfss.bitsel", 32'(bitSelOut), 32'd1);
        execCycle("noSkipB", 12'h1E3, 8'h00, ALU_ADDWF, 2'b00, 8'hE3, S_WRF | S_WRS | S_PCI);
        execCycle("btfssYes",12'h723, 8'h02, ALU_MOVF,  2'b00, 8'h23, S_PCI);
        execCycle("flushB",  12'h1E3, 8'h00, ALU_IDLE,  2'b00, 8'h00, S_PCI);

        execCycle("incfsz",  12'h3E5, 8'h00, ALU_INCF,  2'b00, 8'hE5, S_WRF | S_PCI);
        execCycle("flushC",  12'h1E3, 8'h00, ALU_IDLE,  2'b00, 8'h00, S_PCI);
        execCycle("btfscYes",12'h643, 8'hFB, ALU_MOVF,  2'b00, 8'h43, S_PCI);
        execCycle("flushD",  12'h1E3, 8'h00, ALU_IDLE,  2'b00, 8'h00, S_PCI);
        execCycle("btfscNo", 12'h643, 8'h04, ALU_MOVF,  2'b00, 8'h43, S_PCI);
        execCycle("noSkipC", 12'h1E3, 8'h00, ALU_ADDWF, 2'b00, 8'hE3, S_WRF | S_WRS | S_PCI);

        execCycle("call",    12'h955, 8'h00, ALU_IDLE,  2'b00, 8'h55, S_PCL | S_PUSH);
        chk("call.addr", 32'(pcLoadAddrOut), 32'h055);
        execCycle("flushE",  12'h1E3, 8'h00, ALU_IDLE,  2'b00, 8'h00, S_PCI);

        execCycle("retlw",   12'h8A5, 8'h00, ALU_IORLW, 2'b10, 8'hA5, S_WRW | S_PCL | S_PCS | S_POP);
        execCycle("flushF",  12'hC12, 8'h00, ALU_IDLE,  2'b00, 8'h00, S_PCI);

        execCycle("goto",    12'hBFF, 8'h00, ALU_IDLE,  2'b00, 8'hFF, S_PCL);
        chk("goto.addr", 32'(pcLoadAddrOut), 32'h1FF);
        execCycle("flushG",  12'h1E3, 8'h00, ALU_IDLE,  2'b00, 8'h00, S_PCI);

        for (int i = 0; i < 14; i++) begin
            w = tbl[i].inst;
            execCycle($sformatf("tbl%0d", i), w, 8'h00, tbl[i].func, tbl[i].zero, w[7:0], tbl[i].stb);
        end

        // Reset asserted in Q3 of an ADDWF: no write strobe may follow
        instIn = 12'h1E3;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid.q3en", 32'(aluEnOut), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.phase", 32'(qPhaseOut), 32'd0);
        chk("mid.func",  32'(aluFuncOut), 32'(ALU_IDLE));
        chk("mid.stb",   32'({aluEnOut, stb}), 32'd0);
        chk("mid.flds",  32'({zeroWOut, zeroFOut, litOut, pcLoadAddrOut}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid.hold%0d", i), 32'({aluEnOut, stb}), 32'd0);
        end
        rst_n = 1'b1;
        chk("rel.phase0", 32'(qPhaseOut), 32'd0);
        @(negedge clk);
        chk("rel.phase1", 32'(qPhaseOut), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rel.phase3", 32'(qPhaseOut), 32'd3);
        chk("rel.nopq4",  32'({aluEnOut, stb}), 32'(S_PCI));
        execCycle("reladdwf", 12'h1E3, 8'h10, ALU_ADDWF, 2'b00, 8'hE3, S_WRF | S_WRS | S_PCI);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
